csma_backoff_engine: RTL and testbench

CSMA_BACKOFF_ENGINE -- requirements
Module: csma_backoff_engine

---
 rtl/carriersense_pkg.sv | 20 ++
 rtl/backoff_lfsr_window.sv | 67 ++++++
 rtl/csma_backoff_engine.sv | 128 ++++++++++++
 tb/tb_csma_backoff_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/carriersense_pkg.sv
// Shared definitions for the CSMA backoff engine: FSM state names,
// LFSR feedback taps and the default LFSR seed.
package carriersense_pkg;

   // Backoff FSM states; all four 2-bit codes are used
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_SENDING   = 2'd2,
      ST_DROP      = 2'd3
   } cs_state_t;

   // Feedback taps b31, b21, b1, b0 of the 32-bit Fibonacci LFSR
   localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
   localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hAAAA_AAAA;

   // Width of the retry counter
   localparam int RETRY_W = 4;

endpackage

// File: rtl/backoff_lfsr_window.sv
// Pseudo-random source and contention-window logic. Provides the current
// window plus two registered scaled random values: one masked by the
// current window and one masked by the window of the next retry, so a
// collision can load a countdown drawn from the enlarged window.
module backoff_lfsr_window
   import carriersense_pkg::*;
#(
   parameter int          CNT_W     = 32,
   parameter int          MIN_EXP   = 1,
   parameter int          MAX_EXP   = 10,
   parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic [RETRY_W-1:0] retry_count,
   input  logic [CNT_W-1:0]   max_backoff,
   output logic [CNT_W-1:0]   window,
   output logic [CNT_W-1:0]   random_scaled,
   output logic [CNT_W-1:0]   random_scaled_retry
);

   logic [31:0]      lfsr_reg;
   logic [CNT_W-1:0] random_scaled_reg;
   logic [CNT_W-1:0] random_scaled_retry_reg;
   logic [6:0]       exp_cur;
   logic [6:0]       exp_inc;
   logic [CNT_W-1:0] mask_cur;
   logic [CNT_W-1:0] mask_inc;
   logic [CNT_W-1:0] window_inc;

   // Clamp an exponent to the configured ceiling
   function automatic logic [6:0] cap_exp(input logic [6:0] e);
      return (e > 7'(MAX_EXP)) ? 7'(MAX_EXP) : e;
   endfunction

   assign exp_cur = cap_exp(7'(MIN_EXP) + {3'd0, retry_count});
   assign exp_inc = cap_exp(7'(MIN_EXP) + {3'd0, retry_count} + 7'd1);

   // (1 << exp) - 1 built bit by bit, which stays valid when exp == CNT_W
   generate
      for (genvar gi = 0; gi < CNT_W; gi++) begin : g_mask
         assign mask_cur[gi] = (7'(gi) < exp_cur);
         assign mask_inc[gi] = (7'(gi) < exp_inc);
      end
   endgenerate

   assign window     = mode ? (mask_cur & max_backoff) : max_backoff;
   assign window_inc = mode ? (mask_inc & max_backoff) : max_backoff;

   // LFSR advances every cycle; scaled values are sampled one cycle behind
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_reg                <= LFSR_SEED;
         random_scaled_reg       <= '0;
         random_scaled_retry_reg <= '0;
      end else begin
         lfsr_reg                <= {lfsr_reg[30:0], ^(lfsr_reg & LFSR_TAPS)};
         random_scaled_reg       <= lfsr_reg[CNT_W-1:0] & window;
         random_scaled_retry_reg <= lfsr_reg[CNT_W-1:0] & window_inc;
      end
   end

   assign random_scaled       = random_scaled_reg;
   assign random_scaled_retry = random_scaled_retry_reg;

endmodule

// File: rtl/csma_backoff_engine.sv
// CSMA backoff engine: gates the TX chain on carrier sense, runs a random
// countdown (fixed or binary-exponential window) before transmitting, and
// retries on collision until the retry limit, after which the frame drops.
module csma_backoff_engine
   import carriersense_pkg::*;
#(
   parameter int          CNT_W     = 32,
   parameter int          MIN_EXP   = 1,
   parameter int          MAX_EXP   = 10,
   parameter int          MAX_RETRY = 7,
   parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               strobe,
   input  logic               enable,
   input  logic               run_tx,
   input  logic               run_rx,
   input  logic               data_waiting,
   input  logic               mode,
   input  logic               burst_done,
   input  logic               burst_collision,
   input  logic [CNT_W-1:0]   max_backoff,
   input  logic               carrier_present_from_cs,
   output logic               carrier_present_out,
   output logic               backoff_active,
   output logic [RETRY_W-1:0] retry_count,
   output logic [CNT_W-1:0]   window_out,
   output logic               frame_drop
);

   cs_state_t          state_reg;
   logic               carrier_reg;
   logic [CNT_W-1:0]   countdown_reg;
   logic [RETRY_W-1:0] retry_reg;
   logic               frame_drop_reg;
   logic [CNT_W-1:0]   random_scaled;
   logic [CNT_W-1:0]   random_scaled_retry;
   logic               tx_request;

   backoff_lfsr_window #(
      .CNT_W     (CNT_W),
      .MIN_EXP   (MIN_EXP),
      .MAX_EXP   (MAX_EXP),
      .LFSR_SEED (LFSR_SEED)
   ) u_lfsr (
      .clk                 (clk),
      .rst                 (rst),
      .mode                (mode),
      .retry_count         (retry_reg),
      .max_backoff         (max_backoff),
      .window              (window_out),
      .random_scaled       (random_scaled),
      .random_scaled_retry (random_scaled_retry)
   );

   assign tx_request = enable & run_tx & strobe & data_waiting;

   // Backoff FSM with registered carrier gate, retry counter and drop pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ST_IDLE;
         carrier_reg    <= 1'b0;
         countdown_reg  <= '0;
         retry_reg      <= '0;
         frame_drop_reg <= 1'b0;
      end else begin
         frame_drop_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               carrier_reg <= carrier_present_from_cs;
               if (tx_request) begin
                  if (carrier_reg) begin
                     state_reg     <= ST_COUNTDOWN;
                     countdown_reg <= random_scaled;
                  end else begin
                     state_reg <= ST_SENDING;
                  end
               end
            end
            ST_COUNTDOWN: begin
               carrier_reg <= 1'b1;
               if (!enable) begin
                  state_reg <= ST_IDLE;
                  retry_reg <= '0;
               end else if (countdown_reg == '0) begin
                  // Expired: wait (frozen) until the medium is clear
                  if (!carrier_present_from_cs)
                     state_reg <= ST_SENDING;
               end else if (run_rx && strobe && !carrier_present_from_cs) begin
                  countdown_reg <= countdown_reg - CNT_W'(1);
               end
            end
            ST_SENDING: begin
               carrier_reg <= carrier_present_from_cs;
               if (burst_collision) begin
                  if (retry_reg < RETRY_W'(MAX_RETRY)) begin
                     state_reg     <= ST_COUNTDOWN;
                     retry_reg     <= retry_reg + RETRY_W'(1);
                     countdown_reg <= random_scaled_retry;
                  end else begin
                     state_reg      <= ST_DROP;
                     frame_drop_reg <= 1'b1;
                  end
               end else if (burst_done) begin
                  state_reg <= ST_IDLE;
                  retry_reg <= '0;
               end
            end
            ST_DROP: begin
               carrier_reg <= carrier_present_from_cs;
               retry_reg   <= '0;
               state_reg   <= ST_IDLE;
            end
            default: begin
               state_reg   <= ST_IDLE;
               carrier_reg <= carrier_present_from_cs;
            end
         endcase
      end
   end

   assign carrier_present_out = carrier_reg;
   assign backoff_active      = (state_reg == ST_COUNTDOWN);
   assign retry_count         = retry_reg;
   assign frame_drop          = frame_drop_reg;

endmodule

// File: tb/tb_csma_backoff_engine.sv
// Bench for csma_backoff_engine: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural model of the engine.
module tb_csma_backoff_engine;
   import carriersense_pkg::*;

   localparam int CNT_W     = 16;
   localparam int MIN_EXP   = 1;
   localparam int MAX_EXP   = 10;
   localparam int MAX_RETRY = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             strobe = 1'b0, enable = 1'b0, run_tx = 1'b0, run_rx = 1'b0;
   logic             data_waiting = 1'b0, mode = 1'b0;
   logic             burst_done = 1'b0, burst_collision = 1'b0;
   logic [CNT_W-1:0] max_backoff = '0;
   logic             carrier_present_from_cs = 1'b0;
   logic             carrier_present_out, backoff_active, frame_drop;
   logic [3:0]       retry_count;
   logic [CNT_W-1:0] window_out;

   int n_chk = 0;
   int n_err = 0;

   // behavioural model state
   cs_state_t   m_state;
   logic        m_cpo, m_fd;
   int          m_cnt, m_retry, m_rs, m_rs_inc;
   logic [31:0] m_lfsr;

   csma_backoff_engine #(
      .CNT_W (CNT_W), .MIN_EXP (MIN_EXP), .MAX_EXP (MAX_EXP), .MAX_RETRY (MAX_RETRY)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .strobe                  (strobe),
      .enable                  (enable),
      .run_tx                  (run_tx),
      .run_rx                  (run_rx),
      .data_waiting            (data_waiting),
      .mode                    (mode),
      .burst_done              (burst_done),
      .burst_collision         (burst_collision),
      .max_backoff             (max_backoff),
      .carrier_present_from_cs (carrier_present_from_cs),
      .carrier_present_out     (carrier_present_out),
      .backoff_active          (backoff_active),
      .retry_count             (retry_count),
      .window_out              (window_out),
      .frame_drop              (frame_drop)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // contention window straight from the arithmetic definition
   function automatic int win(input int retry, input logic md, input logic [CNT_W-1:0] mb);
      longint unsigned e;
      longint unsigned mask;
      if (!md) return int'(mb);
      e = longint'(MIN_EXP + retry);
      if (e > longint'(MAX_EXP)) e = longint'(MAX_EXP);
      mask = (64'd1 << e) - 64'd1;
      return int'(mask & {48'd0, mb});
   endfunction

   task automatic model_reset();
      m_state = ST_IDLE; m_cpo = 1'b0; m_fd = 1'b0;
      m_cnt = 0; m_retry = 0; m_rs = 0; m_rs_inc = 0;
      m_lfsr = 32'hAAAA_AAAA;
   endtask

   // one rising edge of the reference behaviour, using pre-edge inputs
   task automatic model_edge();
      int   sc, sci;
      logic fb;
      sc  = int'(m_lfsr[CNT_W-1:0]) & win(m_retry, mode, max_backoff);
      sci = int'(m_lfsr[CNT_W-1:0]) & win(m_retry + 1, mode, max_backoff);
      fb  = m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0];
      m_fd = 1'b0;
      case (m_state)
         ST_IDLE: begin
            if (enable && run_tx && strobe && data_waiting) begin
               if (m_cpo) begin m_state = ST_COUNTDOWN; m_cnt = m_rs; end
               else m_state = ST_SENDING;
            end
            m_cpo = carrier_present_from_cs;
         end
         ST_COUNTDOWN: begin
            m_cpo = 1'b1;
            if (!enable) begin m_state = ST_IDLE; m_retry = 0; end
            else if (m_cnt == 0) begin
               if (!carrier_present_from_cs) m_state = ST_SENDING;
            end else if (run_rx && strobe && !carrier_present_from_cs) m_cnt = m_cnt - 1;
         end
         ST_SENDING: begin
            m_cpo = carrier_present_from_cs;
            if (burst_collision) begin
               if (m_retry < MAX_RETRY) begin
                  m_state = ST_COUNTDOWN; m_retry = m_retry + 1; m_cnt = m_rs_inc;
               end else begin
                  m_state = ST_DROP; m_fd = 1'b1;
               end
            end else if (burst_done) begin
               m_state = ST_IDLE; m_retry = 0;
            end
         end
         default: begin
            m_cpo = carrier_present_from_cs; m_retry = 0; m_state = ST_IDLE;
         end
      endcase
      m_lfsr   = {m_lfsr[30:0], fb};
      m_rs     = sc;
      m_rs_inc = sci;
   endtask

   task automatic check_outputs();
      check_eq("carrier_out", 32'(carrier_present_out), 32'(m_cpo));
      check_eq("backoff_active", 32'(backoff_active), 32'(m_state == ST_COUNTDOWN));
      check_eq("retry_count", 32'(retry_count), 32'(m_retry));
      check_eq("window_out", 32'(window_out), 32'(win(m_retry, mode, max_backoff)));
      check_eq("frame_drop", 32'(frame_drop), 32'(m_fd));
      check_eq("state", 32'(dut.state_reg), 32'(m_state));
      check_eq("countdown", 32'(dut.countdown_reg), 32'(m_cnt));
   endtask

   // advance one clock: model follows the edge, outputs compared on the falling edge
   task automatic cycle();
      @(posedge clk);
      if (rst) model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic wait_state(input cs_state_t s, input int budget);
      int n = 0;
      while (m_state != s && n < budget) begin cycle(); n++; end
      if (m_state != s) check_eq("wait_timeout", 32'(n), 32'(budget + 1));
   endtask

   // async reset asserted between clock edges, checked before the next edge
   task automatic pulse_reset();
      #2 rst = 1'b0;
      #1 model_reset();
      check_eq("rst_carrier", 32'(carrier_present_out), 32'd0);
      check_eq("rst_retry", 32'(retry_count), 32'd0);
      check_eq("rst_state", 32'(dut.state_reg), 32'(ST_IDLE));
      check_eq("rst_lfsr", dut.u_lfsr.lfsr_reg, 32'hAAAA_AAAA);
      @(negedge clk);
      rst = 1'b1;
   endtask

   logic       pass_seq [4];
   int         exp_win [3];

   initial begin
      pass_seq = '{1'b0, 1'b1, 1'b1, 1'b0};
      exp_win  = '{3, 7, 15};
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_outputs();
      check_eq("reset_lfsr", dut.u_lfsr.lfsr_reg, 32'hAAAA_AAAA);
      rst = 1'b1;

      // pass-through with backoff disabled
      for (int i = 0; i < 4; i++) begin
         carrier_present_from_cs = pass_seq[i];
         cycle();
         check_eq("passthru", 32'(carrier_present_out), 32'(pass_seq[i]));
         check_eq("passthru_idle", 32'(dut.state_reg), 32'(ST_IDLE));
      end

      // clear medium: straight to SENDING, then done
      enable = 1'b1; run_tx = 1'b1; data_waiting = 1'b1; strobe = 1'b1;
      cycle();
      strobe = 1'b0;
      check_eq("clear_sending", 32'(dut.state_reg), 32'(ST_SENDING));
      check_eq("clear_carrier", 32'(carrier_present_out), 32'd0);
      burst_done = 1'b1;
      cycle();
      burst_done = 1'b0;
      check_eq("done_idle", 32'(dut.state_reg), 32'(ST_IDLE));
      check_eq("done_retry", 32'(retry_count), 32'd0);

      // zero window with busy medium: frozen at countdown 0
      carrier_present_from_cs = 1'b1;
      cycle(); cycle();
      strobe = 1'b1;
      cycle();
      check_eq("zero_countdown_state", 32'(dut.state_reg), 32'(ST_COUNTDOWN));
      check_eq("zero_countdown_val", 32'(dut.countdown_reg), 32'd0);
      run_rx = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      check_eq("zero_hold", 32'(dut.state_reg), 32'(ST_COUNTDOWN));
      carrier_present_from_cs = 1'b0; strobe = 1'b0;
      cycle();
      check_eq("zero_release", 32'(dut.state_reg), 32'(ST_SENDING));
      burst_done = 1'b1; cycle(); burst_done = 1'b0;

      // exponential windows across collisions, then drop
      mode = 1'b1; max_backoff = '1;
      cycle();
      strobe = 1'b1; cycle(); strobe = 1'b0;
      check_eq("exp_sending", 32'(dut.state_reg), 32'(ST_SENDING));
      check_eq("exp_window0", 32'(window_out), 32'd1);
      for (int k = 0; k < 3; k++) begin
         burst_collision = 1'b1; burst_done = (k == 0);
         cycle();
         burst_collision = 1'b0; burst_done = 1'b0;
         check_eq("exp_retry", 32'(retry_count), 32'(k + 1));
         check_eq("exp_window", 32'(window_out), 32'(exp_win[k]));
         strobe = 1'b1;
         wait_state(ST_SENDING, 200);
         strobe = 1'b0;
      end
      burst_collision = 1'b1;
      cycle();
      burst_collision = 1'b0;
      check_eq("drop_pulse", 32'(frame_drop), 32'd1);
      cycle();
      check_eq("drop_pulse_end", 32'(frame_drop), 32'd0);
      check_eq("drop_retry", 32'(retry_count), 32'd0);
      check_eq("drop_idle", 32'(dut.state_reg), 32'(ST_IDLE));

      // reset in the middle of a countdown
      mode = 1'b0; max_backoff = 16'h00FF;
      cycle();
      strobe = 1'b1; cycle(); strobe = 1'b0;
      burst_collision = 1'b1; cycle(); burst_collision = 1'b0;
      carrier_present_from_cs = 1'b1;
      cycle();
      check_eq("mid_cd_state", 32'(dut.state_reg), 32'(ST_COUNTDOWN));
      pulse_reset();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         enable                  = ($urandom_range(0, 19) != 0);
         run_tx                  = ($urandom_range(0, 9) != 0);
         data_waiting            = ($urandom_range(0, 9) < 7);
         strobe                  = $urandom_range(0, 1) == 1;
         run_rx                  = ($urandom_range(0, 9) < 8);
         carrier_present_from_cs = ($urandom_range(0, 9) < 3);
         burst_done              = ($urandom_range(0, 9) == 0);
         burst_collision         = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 99) == 0) mode = ~mode;
         if ($urandom_range(0, 99) == 0)
            max_backoff = mode ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 63));
         if (!mode && max_backoff > 63) max_backoff = CNT_W'($urandom_range(0, 63));
         if ($urandom_range(0, 499) == 0) pulse_reset();
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
